rgb_pwm_driver: RTL and testbench

Three-channel 8-bit PWM driver that turns per-channel duty values into the RGB LED pin drive for the iceBlinkPico rgb designs. It sits directly downstream of the colour/hue sequencer inside `top`: the sequencer presents new duty values with a load strobe, and this block double-buffers them, applies them only on PWM period boundaries (glitch-free colour changes), and drives `RGB_R/G/B`. A one-cycle `period_start` pulse paces the upstream sequencer.

---
 rtl/rgb_pwm_driver_if.sv | 23 ++
 rtl/rgb_pwm_driver.sv | 113 +++++++++++
 tb/tb_rgb_pwm_driver.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_driver_if.sv
// Duty-update channel between the colour/hue sequencer and rgb_pwm_driver.
//   duty_r/g/b   : new per-channel duty values (sequencer -> driver)
//   load         : one-cycle strobe, capture duty_* into the shadow registers
//   pending      : shadow holds values not yet applied (driver -> sequencer)
//   period_start : one-cycle pulse in the first cycle of each PWM period
interface rgb_pwm_driver_if;
   logic [7:0] duty_r;
   logic [7:0] duty_g;
   logic [7:0] duty_b;
   logic       load;
   logic       pending;
   logic       period_start;

   modport master (
      output duty_r, duty_g, duty_b, load,
      input  pending, period_start
   );

   modport slave (
      input  duty_r, duty_g, duty_b, load,
      output pending, period_start
   );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM driver for the RGB LED pins.
// Duty values from the sequencer are double-buffered: a load writes the
// shadow registers, and the shadow is moved into the active registers only
// on a PWM period boundary, so a colour change never cuts a period short.
//   CLK          : system clock, rising edge
//   RST          : synchronous, active-high reset
//   bus          : duty/load in, pending/period_start out (slave modport)
//   RGB_R/G/B    : registered pin drive, polarity set by ACTIVE_LOW
// Parameters:
//   PRESCALE     : one PWM step every PRESCALE+1 clocks (0 = every clock)
//   ACTIVE_LOW   : 1 drives a pin low while its channel is on
module rgb_pwm_driver #(
   parameter int unsigned PRESCALE   = 47,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic            CLK,
   input  logic            RST,
   rgb_pwm_driver_if.slave bus,
   output logic            RGB_R,
   output logic            RGB_G,
   output logic            RGB_B
);

   localparam int unsigned      PRE_W    = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE);

   logic [PRE_W-1:0]  pre_cnt;
   logic [7:0]        pwm_cnt;
   logic              tick;
   logic              boundary;

   // index 0 = red, 1 = green, 2 = blue
   logic [2:0][7:0]   duty_in;
   logic [2:0][7:0]   shadow;
   logic [2:0][7:0]   active;
   logic              pending_q;
   logic              period_start_q;
   logic [2:0]        on;
   logic [2:0]        pin_q;

   assign duty_in = {bus.duty_b, bus.duty_g, bus.duty_r};

   assign tick     = (pre_cnt == PRE_LAST);
   assign boundary = tick && (pwm_cnt == 8'hFF);

   // prescaler and PWM step counter; pwm_cnt wraps 255 -> 0 naturally
   always_ff @(posedge CLK) begin
      if (RST) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Shadow capture. A load in the boundary cycle wins over the clear so the
   // freshly written values stay pending for the following boundary.
   always_ff @(posedge CLK) begin
      if (RST) begin
         shadow    <= '0;
         pending_q <= 1'b0;
      end else if (bus.load) begin
         shadow    <= duty_in;
         pending_q <= 1'b1;
      end else if (boundary) begin
         pending_q <= 1'b0;
      end
   end

   // Active duties change only at the boundary and take the shadow as it
   // stood before this cycle's load, if any.
   always_ff @(posedge CLK) begin
      if (RST) begin
         active <= '0;
      end else if (boundary && pending_q) begin
         active <= shadow;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         period_start_q <= 1'b0;
      end else begin
         period_start_q <= boundary;
      end
   end

   // duty 0 is never on, duty 255 is on for 255 of 256 steps
   always_comb begin
      on = '0;
      for (int c = 0; c < 3; c++) begin
         on[c] = (pwm_cnt < active[c]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pin_q <= {3{ACTIVE_LOW}};
      end else begin
         pin_q <= on ^ {3{ACTIVE_LOW}};
      end
   end

   assign RGB_R            = pin_q[0];
   assign RGB_G            = pin_q[1];
   assign RGB_B            = pin_q[2];
   assign bus.pending      = pending_q;
   assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: one instance with PRESCALE=0 and one with
// PRESCALE=2, both ACTIVE_LOW=1. A period-position model predicts every
// output each cycle; directed literal checks pin the model's timing.
module tb_rgb_pwm_driver;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST0;
   logic RST2;
   logic r0, g0, b0, r2, g2, b2;

   rgb_pwm_driver_if if0 ();
   rgb_pwm_driver_if if2 ();

   rgb_pwm_driver #(.PRESCALE(0), .ACTIVE_LOW(1'b1)) dut0 (
      .CLK   (CLK),
      .RST   (RST0),
      .bus   (if0),
      .RGB_R (r0),
      .RGB_G (g0),
      .RGB_B (b0)
   );

   rgb_pwm_driver #(.PRESCALE(2), .ACTIVE_LOW(1'b1)) dut2 (
      .CLK   (CLK),
      .RST   (RST2),
      .bus   (if2),
      .RGB_R (r2),
      .RGB_G (g2),
      .RGB_B (b2)
   );

   // flat views of both instances
   logic       rst_v  [2];
   logic       load_v [2];
   logic       pend_v [2];
   logic       ps_v   [2];
   logic [7:0] duty_v [2][3];
   logic       pin_v  [2][3];

   assign rst_v[0]     = RST0;
   assign rst_v[1]     = RST2;
   assign load_v[0]    = if0.load;
   assign load_v[1]    = if2.load;
   assign pend_v[0]    = if0.pending;
   assign pend_v[1]    = if2.pending;
   assign ps_v[0]      = if0.period_start;
   assign ps_v[1]      = if2.period_start;
   assign duty_v[0][0] = if0.duty_r;
   assign duty_v[0][1] = if0.duty_g;
   assign duty_v[0][2] = if0.duty_b;
   assign duty_v[1][0] = if2.duty_r;
   assign duty_v[1][1] = if2.duty_g;
   assign duty_v[1][2] = if2.duty_b;
   assign pin_v[0][0]  = r0;
   assign pin_v[0][1]  = g0;
   assign pin_v[0][2]  = b0;
   assign pin_v[1][0]  = r2;
   assign pin_v[1][1]  = g2;
   assign pin_v[1][2]  = b2;

   int n_checks = 0;
   int n_errors = 0;
   int abs_cyc  = 0;

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each instance is described by its position inside the current period
   // (0 .. 256*(P+1)-1); the PWM step is position/(P+1).
   int  pre_v [2] = '{0, 2};
   bit  m_valid [2];
   int  m_pos [2];
   bit  m_pend [2];
   int  m_shadow [2][3];
   int  m_active [2][3];
   bit  e_on [2][3];
   bit  e_pend [2];
   bit  e_ps [2];
   int  len_m;
   int  step_m;
   bit  bnd_m;

   initial begin
      for (int i = 0; i < 2; i++) m_valid[i] = 1'b0;
      forever begin
         @(posedge CLK);
         for (int i = 0; i < 2; i++) begin
            if (rst_v[i]) begin
               m_valid[i] = 1'b1;
               m_pos[i]   = 0;
               m_pend[i]  = 1'b0;
               e_pend[i]  = 1'b0;
               e_ps[i]    = 1'b0;
               for (int c = 0; c < 3; c++) begin
                  m_shadow[i][c] = 0;
                  m_active[i][c] = 0;
                  e_on[i][c]     = 1'b0;
               end
            end else if (m_valid[i]) begin
               len_m  = 256 * (pre_v[i] + 1);
               step_m = m_pos[i] / (pre_v[i] + 1);
               bnd_m  = (m_pos[i] == len_m - 1);
               for (int c = 0; c < 3; c++) e_on[i][c] = (step_m < m_active[i][c]);
               e_ps[i] = bnd_m;
               if (bnd_m) begin
                  if (m_pend[i])
                     for (int c = 0; c < 3; c++) m_active[i][c] = m_shadow[i][c];
                  m_pend[i] = 1'b0;
               end
               if (load_v[i]) begin
                  for (int c = 0; c < 3; c++) m_shadow[i][c] = int'(duty_v[i][c]);
                  m_pend[i] = 1'b1;
               end
               e_pend[i] = m_pend[i];
               m_pos[i]  = (m_pos[i] + 1) % len_m;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge CLK);
         for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
               for (int c = 0; c < 3; c++)
                  chk($sformatf("dut%0d pin%0d abs %0d", i, c, abs_cyc),
                      int'(pin_v[i][c]), int'(!e_on[i][c]));
               chk($sformatf("dut%0d pending abs %0d", i, abs_cyc), int'(pend_v[i]), int'(e_pend[i]));
               chk($sformatf("dut%0d period_start abs %0d", i, abs_cyc), int'(ps_v[i]), int'(e_ps[i]));
            end
         end
      end
   end

   // ---------------- history for literal checks ----------------
   // signal index: 0 R, 1 G, 2 B, 3 pending, 4 period_start
   localparam int HMAX = 8192;
   logic h [2][5][HMAX];

   task automatic tick();
      @(negedge CLK);
      abs_cyc++;
      if (abs_cyc >= HMAX) begin
         $display("FAIL history bound: got %0d, expected below %0d", abs_cyc, HMAX);
         $fatal(1, "cycle budget exceeded");
      end
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < 3; c++) h[i][c][abs_cyc] = pin_v[i][c];
         h[i][3][abs_cyc] = pend_v[i];
         h[i][4][abs_cyc] = ps_v[i];
      end
   endtask

   task automatic go(int base, int rel);
      while (abs_cyc < base + rel) tick();
   endtask

   function automatic int hv(int inst, int sig, int base, int rel);
      return int'(h[inst][sig][base + rel]);
   endfunction

   function automatic int count_eq(int inst, int sig, int base, int a, int b, logic v);
      int n = 0;
      for (int k = a; k <= b; k++) if (h[inst][sig][base + k] == v) n++;
      return n;
   endfunction

   task automatic do_load(int inst, int base, int rel, int r, int g, int b);
      go(base, rel);
      if (inst == 0) begin
         if0.duty_r = 8'(r);
         if0.duty_g = 8'(g);
         if0.duty_b = 8'(b);
         if0.load   = 1'b1;
      end else begin
         if2.duty_r = 8'(r);
         if2.duty_g = 8'(g);
         if2.duty_b = 8'(b);
         if2.load   = 1'b1;
      end
      tick();
      if0.load = 1'b0;
      if2.load = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   int base0;
   int base2;

   initial begin
      RST0 = 1'b1;
      RST2 = 1'b1;
      if0.duty_r = '0; if0.duty_g = '0; if0.duty_b = '0; if0.load = 1'b0;
      if2.duty_r = '0; if2.duty_g = '0; if2.duty_b = '0; if2.load = 1'b0;

      repeat (3) tick();
      RST0  = 1'b0;
      base0 = abs_cyc;

      chk("reset R", hv(0, 0, base0, 0), 1);
      chk("reset G", hv(0, 1, base0, 0), 1);
      chk("reset B", hv(0, 2, base0, 0), 1);
      chk("reset pending", hv(0, 3, base0, 0), 0);
      chk("reset period_start", hv(0, 4, base0, 0), 0);

      // basic colour
      do_load(0, base0, 10, 64, 128, 0);
      go(base0, 300);
      chk("pending before load", hv(0, 3, base0, 10), 0);
      chk("pending after load", hv(0, 3, base0, 11), 1);
      chk("pending at 255", hv(0, 3, base0, 255), 1);
      chk("pending cleared 256", hv(0, 3, base0, 256), 0);
      chk("ps at 255", hv(0, 4, base0, 255), 0);
      chk("ps first at 256", hv(0, 4, base0, 256), 1);
      chk("ps off 257", hv(0, 4, base0, 257), 0);
      chk("ps count 0..255", count_eq(0, 4, base0, 0, 255, 1'b1), 0);

      do_load(0, base0, 600, 255, 0, 0);
      go(base0, 1030);
      chk("R low p1", count_eq(0, 0, base0, 257, 512, 1'b0), 64);
      chk("G low p1", count_eq(0, 1, base0, 257, 512, 1'b0), 128);
      chk("B low p1", count_eq(0, 2, base0, 257, 512, 1'b0), 0);
      chk("R last low 320", hv(0, 0, base0, 320), 0);
      chk("R first high 321", hv(0, 0, base0, 321), 1);
      chk("G last low 384", hv(0, 1, base0, 384), 0);
      chk("G first high 385", hv(0, 1, base0, 385), 1);
      chk("R low p2 repeat", count_eq(0, 0, base0, 513, 768, 1'b0), 64);
      chk("G low p2 repeat", count_eq(0, 1, base0, 513, 768, 1'b0), 128);

      // extremes
      chk("R duty255 low", count_eq(0, 0, base0, 769, 1024, 1'b0), 255);
      chk("G duty0 low", count_eq(0, 1, base0, 769, 1024, 1'b0), 0);
      chk("R duty255 high slot", hv(0, 0, base0, 1024), 1);
      chk("R duty255 wrap", hv(0, 0, base0, 1025), 0);

      // last load before a boundary wins
      do_load(0, base0, 1100, 10, 0, 0);
      do_load(0, base0, 1110, 200, 0, 0);
      // load one, then another exactly at boundary 1535
      do_load(0, base0, 1400, 77, 0, 0);
      do_load(0, base0, 1535, 50, 0, 0);
      do_load(0, base0, 1800, 128, 0, 0);
      go(base0, 2060);
      chk("R last-wins 200", count_eq(0, 0, base0, 1281, 1536, 1'b0), 200);
      chk("pending at 1536", hv(0, 3, base0, 1536), 1);
      chk("pending at 1791", hv(0, 3, base0, 1791), 1);
      chk("pending cleared 1792", hv(0, 3, base0, 1792), 0);
      chk("R old shadow 77", count_eq(0, 0, base0, 1537, 1792, 1'b0), 77);
      chk("R boundary load 50", count_eq(0, 0, base0, 1793, 2048, 1'b0), 50);

      // reset mid-operation with r=128 active and a load pending
      do_load(0, base0, 2100, 30, 0, 0);
      go(base0, 2150);
      chk("R128 on at 2150", hv(0, 0, base0, 2150), 0);
      chk("pending before reset", hv(0, 3, base0, 2150), 1);
      go(base0, 2200);
      RST0 = 1'b1;
      tick();
      chk("midreset R", hv(0, 0, abs_cyc, 0), 1);
      chk("midreset pending", hv(0, 3, abs_cyc, 0), 0);
      chk("midreset ps", hv(0, 4, abs_cyc, 0), 0);
      RST0  = 1'b0;
      base0 = abs_cyc;
      go(base0, 512);
      chk("post reset ps 255", hv(0, 4, base0, 255), 0);
      chk("post reset ps 256", hv(0, 4, base0, 256), 1);
      chk("post reset ps count", count_eq(0, 4, base0, 0, 255, 1'b1), 0);
      chk("post reset R low", count_eq(0, 0, base0, 1, 512, 1'b0), 0);
      chk("post reset pending", hv(0, 3, base0, 300), 0);

      // PRESCALE=2
      RST2  = 1'b0;
      base2 = abs_cyc;
      do_load(1, base2, 5, 0, 4, 0);
      go(base2, 2304);
      chk("p2 pending after load", hv(1, 3, base2, 6), 1);
      chk("p2 pending cleared", hv(1, 3, base2, 768), 0);
      chk("p2 ps 767", hv(1, 4, base2, 767), 0);
      chk("p2 ps 768", hv(1, 4, base2, 768), 1);
      chk("p2 ps gap", count_eq(1, 4, base2, 769, 1535, 1'b1), 0);
      chk("p2 ps 1536", hv(1, 4, base2, 1536), 1);
      chk("p2 G low", count_eq(1, 1, base2, 769, 1536, 1'b0), 12);
      chk("p2 G low next", count_eq(1, 1, base2, 1537, 2304, 1'b0), 12);
      chk("p2 G first low 769", hv(1, 1, base2, 769), 0);
      chk("p2 G last low 780", hv(1, 1, base2, 780), 0);
      chk("p2 G high 781", hv(1, 1, base2, 781), 1);
      chk("p2 R low", count_eq(1, 0, base2, 769, 1536, 1'b0), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
